// File: rtl/mac_pkg.sv
// Shared definitions for the memory access controller.
// Holds the RV32I load/store funct3 codes, the controller state encoding,
// the default timeout, and small decode helpers for legality, alignment,
// byte-enable generation and store-data replication.
package mac_pkg;

  localparam int unsigned MAC_TIMEOUT_DEF = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } mac_state_e;

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // sz is funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic m;
    case (sz)
      2'b01:   m = off[0];
      2'b10:   m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] be_gen(input logic we, input logic [1:0] sz,
                                        input logic [1:0] off);
    logic [3:0] be;
    if (we) begin
      case (sz)
        2'b00:   be = 4'b0001 << off;
        2'b01:   be = 4'b0011 << {off[1], 1'b0};
        default: be = 4'b1111;
      endcase
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  // Replicate narrow store data across all lanes so the enabled lane sees it.
  function automatic logic [31:0] wdata_gen(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{wd[7:0]}};
      2'b01:   w = {2{wd[15:0]}};
      default: w = wd;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mac_load_align.sv
// Load-data alignment and extension.
// Ports:
//   mdr_i    - registered memory data word
//   off_i    - byte offset of the access within the word
//   funct3_i - load funct3 (LB/LH/LW/LBU/LHU)
//   data_o   - selected lane, sign/zero-extended to 32 bits (0 for other codes)
module mac_load_align
  import mac_pkg::*;
(
  input  logic [31:0] mdr_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection from the byte offset.
  always_comb begin
    byte_s = 8'h00;
    case (off_i)
      2'd0:    byte_s = mdr_i[7:0];
      2'd1:    byte_s = mdr_i[15:8];
      2'd2:    byte_s = mdr_i[23:16];
      2'd3:    byte_s = mdr_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (off_i[1]) begin
      half_s = mdr_i[31:16];
    end else begin
      half_s = mdr_i[15:0];
    end
  end

  // Extension according to the load type.
  always_comb begin
    data_o = 32'h0000_0000;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   data_o = {24'h00_0000, byte_s};
      F3_H:    data_o = {{16{half_s[15]}}, half_s};
      F3_HU:   data_o = {16'h0000, half_s};
      F3_W:    data_o = mdr_i;
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/memory_access_controller.sv
// Load/store sequencer between execute stage and data memory.
// Accepts one access at a time, aligns store data and byte enables, waits for
// mem_ack with a timeout, strobes the external MDR on load return and returns
// the extended MDR contents (or an error) on the response channel.
// Ports:
//   mac_clk/mac_rst_n             - clock, async active-low reset
//   req_*                         - request channel (ready only in IDLE)
//   rsp_*                         - response channel (valid only in RESP)
//   mem_en/we/be/addr/wdata/ack   - memory port; mem_rdata feeds the MDR only
//   mdr_load/mdr_q                - MDR load strobe and registered MDR value
module memory_access_controller
  import mac_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = MAC_TIMEOUT_DEF
) (
  input  logic              mac_clk,
  input  logic              mac_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              mdr_load,
  input  logic [31:0]       mdr_q
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mac_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic              accept_s;
  logic              bad_s;
  logic [31:0]       align_s;
  logic              unused_mem_rdata_s;

  // mem_rdata goes straight to the MDR outside this block.
  assign unused_mem_rdata_s = ^mem_rdata;

  assign accept_s = (state_q == ST_IDLE) & req_valid;
  assign bad_s    = ~f3_legal(req_we, req_funct3) | misaligned(req_funct3[1:0], req_addr[1:0]);

  mac_load_align u_align (
    .mdr_i    (mdr_q),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (align_s)
  );

  // Controls decoded only from registered state (mdr_load also qualifies on mem_ack).
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = (state_q == ST_ACCESS) & we_q;
  assign mdr_load  = (state_q == ST_ACCESS) & mem_ack & ~we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state, timeout counter and response register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rsp_rdata_d = 32'h0000_0000;
          cnt_d       = {CNT_W{1'b0}};
          if (bad_s) begin
            state_d   = ST_RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d   = ST_ACCESS;
            rsp_err_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // An ack in the last allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          if (we_q) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_RESP;
          rsp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        rsp_rdata_d = align_s;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d   = ST_IDLE;
          rsp_err_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and response registers.
  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Request capture; memory-side fields stay stable until the next accept.
  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
    end else if (accept_s) begin
      we_q        <= req_we;
      f3_q        <= req_funct3;
      off_q       <= req_addr[1:0];
      mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
      mem_be_q    <= be_gen(req_we, req_funct3[1:0], req_addr[1:0]);
      mem_wdata_q <= wdata_gen(req_funct3[1:0], req_wdata);
    end else begin
      mem_addr_q  <= mem_addr_q;
    end
  end

endmodule
